// File: rtl/core_sequencer_if.sv
// Instruction-bus and data-bus handshake between the core sequencer and memory.
interface core_sequencer_if;
   logic instr_req;
   logic instr_ready;
   logic data_req;
   logic data_we;
   logic data_ready;

   modport master (
      output instr_req,
      output data_req,
      output data_we,
      input  instr_ready,
      input  data_ready
   );

   modport slave (
      input  instr_req,
      input  data_req,
      input  data_we,
      output instr_ready,
      output data_ready
   );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control FSM: fetch / decode / execute / mem / writeback,
// bus handshakes, cycle and retire counters, and trap on illegal ops or bus timeouts.
module core_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic                    clk,
   input  logic                    reset,
   core_sequencer_if.master        bus,
   input  logic                    halt,
   output logic                    ir_we,
   input  logic                    dec_data_r,
   input  logic                    dec_data_w,
   input  logic                    dec_reg_w,
   input  logic                    dec_branch,
   input  logic                    dec_jump,
   input  logic                    dec_illegal,
   input  logic                    branch_taken,
   output logic                    alu_en,
   output logic                    reg_we,
   output logic                    pc_we,
   output logic                    pc_sel,
   output logic                    busy,
   output logic                    fault,
   output logic [1:0]              fault_code,
   output logic [2:0]              state_o,
   output logic [31:0]             cycle_count,
   output logic [31:0]             instret
);

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEM       = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_FAULT     = 3'd7
   } state_t;

   localparam bit         TIMEOUT_EN = (MEM_TIMEOUT != 0);
   localparam logic [7:0] WAIT_LIMIT = TIMEOUT_EN ? 8'(MEM_TIMEOUT - 1) : 8'd0;

   state_t     state_q;
   state_t     state_d;
   logic [7:0] wait_q;
   logic [1:0] trap_code;
   logic       waiting;
   logic       timeout_hit;

   // A cycle spent waiting on a bus; any other cycle clears the count, so
   // entry into FETCH or MEM always starts from zero.
   assign waiting = ((state_q == ST_FETCH) && !halt && !bus.instr_ready) ||
                    ((state_q == ST_MEM) && !bus.data_ready);

   // Limit reached means this is the MEM_TIMEOUT-th consecutive not-ready cycle.
   assign timeout_hit = TIMEOUT_EN && (wait_q == WAIT_LIMIT);

   assign state_o = state_q;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (reset) state_q <= ST_FETCH;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_q      <= '0;
         cycle_count <= '0;
         instret     <= '0;
         fault       <= 1'b0;
         fault_code  <= 2'b00;
      end else begin
         if (waiting) wait_q <= (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
         else         wait_q <= '0;

         if (state_q != ST_FAULT)     cycle_count <= cycle_count + 32'd1;
         if (state_q == ST_WRITEBACK) instret     <= instret + 32'd1;

         if ((state_q != ST_FAULT) && (state_d == ST_FAULT)) begin
            fault      <= 1'b1;
            fault_code <= trap_code;
         end
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case statement can infer a latch.
      state_d   = state_q;
      trap_code = 2'b11;
      case (state_q)
         ST_FETCH: begin
            if (!halt) begin
               if (bus.instr_ready) begin
                  state_d = ST_DECODE;
               end else if (timeout_hit) begin
                  state_d   = ST_FAULT;
                  trap_code = 2'b01;
               end
            end
         end
         ST_DECODE: begin
            if (dec_illegal || (dec_data_r && dec_data_w)) state_d = ST_FAULT;
            else                                           state_d = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            state_d = (dec_data_r || dec_data_w) ? ST_MEM : ST_WRITEBACK;
         end
         ST_MEM: begin
            if (bus.data_ready) begin
               state_d = ST_WRITEBACK;
            end else if (timeout_hit) begin
               state_d   = ST_FAULT;
               trap_code = 2'b10;
            end
         end
         ST_WRITEBACK: state_d = ST_FETCH;
         ST_FAULT:     state_d = ST_FAULT;
         default:      state_d = ST_FAULT;
      endcase
   end

   always_comb begin
      bus.instr_req = 1'b0;
      ir_we         = 1'b0;
      bus.data_req  = 1'b0;
      bus.data_we   = 1'b0;
      alu_en        = 1'b0;
      reg_we        = 1'b0;
      pc_we         = 1'b0;
      pc_sel        = 1'b0;
      busy          = 1'b0;
      // Reset suppresses every strobe, dropping any request in flight.
      if (!reset) begin
         case (state_q)
            ST_FETCH: begin
               if (!halt) begin
                  bus.instr_req = 1'b1;
                  ir_we         = bus.instr_ready;
                  busy          = 1'b1;
               end
            end
            ST_DECODE: busy = 1'b1;
            ST_EXECUTE: begin
               alu_en = 1'b1;
               busy   = 1'b1;
            end
            ST_MEM: begin
               bus.data_req = 1'b1;
               bus.data_we  = dec_data_w;
               alu_en       = 1'b1;
               busy         = 1'b1;
            end
            ST_WRITEBACK: begin
               reg_we = dec_reg_w & ~dec_data_w & ~dec_branch;
               pc_we  = 1'b1;
               pc_sel = dec_jump | (dec_branch & branch_taken);
               busy   = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: each instruction is expanded into an
// expected per-cycle timeline from its class and bus wait counts, then replayed.
module tb_core_sequencer;

   localparam int unsigned T = 4;

   localparam logic [8:0] B_REQ_I = 9'h100;
   localparam logic [8:0] B_IR    = 9'h080;
   localparam logic [8:0] B_REQ_D = 9'h040;
   localparam logic [8:0] B_WE_D  = 9'h020;
   localparam logic [8:0] B_ALU   = 9'h010;
   localparam logic [8:0] B_REG   = 9'h008;
   localparam logic [8:0] B_PC    = 9'h004;
   localparam logic [8:0] B_SEL   = 9'h002;
   localparam logic [8:0] B_BUSY  = 9'h001;

   typedef enum int {K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JUMP, K_RW} kind_e;

   typedef struct {
      logic [2:0] st;
      logic       halt;
      logic       rdy_i;
      logic       rdy_d;
      logic [8:0] strobes;
      logic       flt;
      logic [1:0] code;
   } step_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        halt;
   logic        ir_we;
   logic        dec_data_r, dec_data_w, dec_reg_w, dec_branch, dec_jump, dec_illegal;
   logic        branch_taken;
   logic        alu_en, reg_we, pc_we, pc_sel, busy, fault;
   logic [1:0]  fault_code;
   logic [2:0]  state_o;
   logic [31:0] cycle_count, instret;

   int          vectors = 0;
   int          miscompares = 0;
   int          step_no = 0;
   logic [31:0] exp_cyc;
   logic [31:0] exp_ret;
   step_t       exp_q[$];

   core_sequencer_if bus ();

   core_sequencer #(.MEM_TIMEOUT(T)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus.master),
      .halt         (halt),
      .ir_we        (ir_we),
      .dec_data_r   (dec_data_r),
      .dec_data_w   (dec_data_w),
      .dec_reg_w    (dec_reg_w),
      .dec_branch   (dec_branch),
      .dec_jump     (dec_jump),
      .dec_illegal  (dec_illegal),
      .branch_taken (branch_taken),
      .alu_en       (alu_en),
      .reg_we       (reg_we),
      .pc_we        (pc_we),
      .pc_sel       (pc_sel),
      .busy         (busy),
      .fault        (fault),
      .fault_code   (fault_code),
      .state_o      (state_o),
      .cycle_count  (cycle_count),
      .instret      (instret)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] strobes_now();
      return {bus.instr_req, ir_we, bus.data_req, bus.data_we, alu_en, reg_we, pc_we, pc_sel, busy};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s @step %0d: observed 0x%0h expected 0x%0h", tag, step_no, obs, exp);
      end
   endtask

   function automatic step_t mk(input logic [2:0] st, input logic [8:0] strobes);
      step_t s;
      s.st      = st;
      s.halt    = 1'b0;
      s.rdy_i   = 1'b0;
      s.rdy_d   = 1'b0;
      s.strobes = strobes;
      s.flt     = 1'b0;
      s.code    = 2'b00;
      return s;
   endfunction

   // Once trapped: no strobes, sticky flag, three cycles to show the freeze.
   function automatic void add_fault(input logic [1:0] code);
      step_t s;
      s      = mk(3'd7, 9'h000);
      s.flt  = 1'b1;
      s.code = code;
      repeat (3) exp_q.push_back(s);
   endfunction

   task automatic run_steps(input int max_steps);
      step_t s;
      int    n;
      n = 0;
      while (exp_q.size() > 0 && n < max_steps) begin
         s = exp_q.pop_front();
         halt            = s.halt;
         bus.instr_ready = s.rdy_i;
         bus.data_ready  = s.rdy_d;
         @(negedge clk);
         chk("state",       32'(state_o),       32'(s.st));
         chk("strobes",     32'(strobes_now()), 32'(s.strobes));
         chk("fault",       32'(fault),         32'(s.flt));
         chk("fault_code",  32'(fault_code),    32'(s.code));
         chk("cycle_count", cycle_count,        exp_cyc);
         chk("instret",     instret,            exp_ret);
         if (s.st != 3'd7) exp_cyc = exp_cyc + 32'd1;
         if (s.st == 3'd4) exp_ret = exp_ret + 32'd1;
         step_no++;
         n++;
         @(posedge clk);
         #1;
      end
      exp_q.delete();
   endtask

   // Reset with every input driven active: all strobes must still be low.
   task automatic reset_dut();
      reset           = 1'b1;
      halt            = 1'b0;
      bus.instr_ready = 1'b1;
      bus.data_ready  = 1'b1;
      dec_data_r      = 1'b0;
      dec_data_w      = 1'b1;
      dec_reg_w       = 1'b1;
      dec_branch      = 1'b1;
      dec_jump        = 1'b1;
      dec_illegal     = 1'b0;
      branch_taken    = 1'b1;
      @(negedge clk);
      chk("reset_strobes", 32'(strobes_now()), 32'd0);
      @(posedge clk);
      #1;
      reset           = 1'b0;
      bus.instr_ready = 1'b0;
      bus.data_ready  = 1'b0;
      chk("rst_state",      32'(state_o),    32'd0);
      chk("rst_fault",      32'(fault),      32'd0);
      chk("rst_fault_code", 32'(fault_code), 32'd0);
      chk("rst_cycle",      cycle_count,     32'd0);
      chk("rst_instret",    instret,         32'd0);
      exp_cyc = 32'd0;
      exp_ret = 32'd0;
   endtask

   // fw / mw: not-ready cycles before the bus answers; a value >= T means it never does.
   task automatic apply_instr(input kind_e k, input bit illegal, input int fw, input int mw,
                              input bit taken, input int halt_n, input int max_steps);
      bit    r, w, rw, br, jmp;
      step_t s;
      logic [8:0] m;
      r   = (k == K_LOAD) || (k == K_RW);
      w   = (k == K_STORE) || (k == K_RW);
      rw  = (k == K_ALU) || (k == K_LOAD) || (k == K_JUMP) || (k == K_RW);
      br  = (k == K_BRANCH);
      jmp = (k == K_JUMP);
      dec_data_r   = r;
      dec_data_w   = w;
      dec_reg_w    = rw;
      dec_branch   = br;
      dec_jump     = jmp;
      dec_illegal  = illegal;
      branch_taken = taken;

      for (int h = 0; h < halt_n; h++) begin
         s      = mk(3'd0, 9'h000);
         s.halt = 1'b1;
         exp_q.push_back(s);
      end

      if (fw >= int'(T)) begin
         for (int t = 0; t < int'(T); t++) exp_q.push_back(mk(3'd0, B_REQ_I | B_BUSY));
         add_fault(2'b01);
      end else begin
         for (int t = 0; t < fw; t++) exp_q.push_back(mk(3'd0, B_REQ_I | B_BUSY));
         s       = mk(3'd0, B_REQ_I | B_IR | B_BUSY);
         s.rdy_i = 1'b1;
         exp_q.push_back(s);
         exp_q.push_back(mk(3'd1, B_BUSY));
         if (illegal || (r && w)) begin
            add_fault(2'b11);
         end else begin
            exp_q.push_back(mk(3'd2, B_ALU | B_BUSY));
            if ((r || w) && mw >= int'(T)) begin
               for (int t = 0; t < int'(T); t++) exp_q.push_back(mk(3'd3, B_REQ_D | B_ALU | B_BUSY | (w ? B_WE_D : 9'h000)));
               add_fault(2'b10);
            end else begin
               if (r || w) begin
                  m = B_REQ_D | B_ALU | B_BUSY | (w ? B_WE_D : 9'h000);
                  for (int t = 0; t < mw; t++) exp_q.push_back(mk(3'd3, m));
                  s       = mk(3'd3, m);
                  s.rdy_d = 1'b1;
                  exp_q.push_back(s);
               end
               m = B_PC | B_BUSY;
               if (rw && !w && !br)       m = m | B_REG;
               if (jmp || (br && taken))  m = m | B_SEL;
               exp_q.push_back(mk(3'd4, m));
            end
         end
      end
      run_steps(max_steps);
   endtask

   initial begin
      reset_dut();

      // ADDI with an always-ready instruction bus, then a slow-data load.
      apply_instr(K_ALU,    1'b0, 0, 0, 1'b0, 0, 1000);
      apply_instr(K_LOAD,   1'b0, 0, 3, 1'b0, 0, 1000);
      // Taken BEQ then not-taken BNE.
      apply_instr(K_BRANCH, 1'b0, 0, 0, 1'b1, 0, 1000);
      apply_instr(K_BRANCH, 1'b0, 0, 0, 1'b0, 0, 1000);
      // Halt longer than the timeout, then a fetch answered at the limit.
      apply_instr(K_ALU,    1'b0, 3, 0, 1'b0, 5, 1000);
      // Store whose data_ready arrives exactly at the limit.
      apply_instr(K_STORE,  1'b0, 0, 3, 1'b0, 0, 1000);
      apply_instr(K_JUMP,   1'b0, 1, 0, 1'b0, 0, 1000);

      for (int i = 0; i < 40; i++) begin
         apply_instr(kind_e'($urandom_range(0, 4)), 1'b0,
                     int'($urandom_range(0, T - 1)), int'($urandom_range(0, T - 1)),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 3)) / 2, 1000);
      end

      // Illegal opcode, then reset out of the trap.
      apply_instr(K_ALU,  1'b1, 0, 0, 1'b0, 0, 1000);
      reset_dut();
      // Load and store flagged together.
      apply_instr(K_RW,   1'b0, 1, 0, 1'b0, 0, 1000);
      reset_dut();
      // Instruction bus never answers.
      apply_instr(K_ALU,  1'b0, T, 0, 1'b0, 0, 1000);
      reset_dut();
      // Data bus never answers.
      apply_instr(K_LOAD, 1'b0, 0, T, 1'b0, 0, 1000);
      reset_dut();
      // Reset lands while a load is waiting in MEM.
      apply_instr(K_LOAD, 1'b0, 0, 3, 1'b0, 0, 4);
      reset_dut();
      apply_instr(K_ALU,  1'b0, 0, 0, 1'b0, 0, 1000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
